// File: rtl/mips_dm_pkg.sv
// rtl/mips_dm_pkg.sv - op codes, byte-enable width and alignment helper for dm_unit
package mips_dm_pkg;

  typedef enum logic [2:0] {
    DM_W  = 3'd0,
    DM_H  = 3'd1,
    DM_B  = 3'd2,
    DM_HU = 3'd3,
    DM_BU = 3'd4
  } dm_op_e;

  localparam int BE_W = 4;

  // Reserved op codes report as misaligned so they can never store.
  function automatic logic dm_misaligned(input logic [2:0] op, input logic [1:0] lane);
    case (op)
      DM_W:         return lane != 2'b00;
      DM_H, DM_HU:  return lane[0];
      DM_B, DM_BU:  return 1'b0;
      default:      return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_unit_if.sv
// rtl/dm_unit_if.sv - load/store access bus between the datapath and dm_unit
interface dm_unit_if;
  logic        we;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        misalign;
  logic        oor;

  modport master (output we, op, addr, wdata, input rdata, misalign, oor);
  modport slave  (input we, op, addr, wdata, output rdata, misalign, oor);
endinterface

// File: rtl/dm_lane.sv
// rtl/dm_lane.sv - byte enables, lane-positioned store word and load extension
module dm_lane
  import mips_dm_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [1:0]      lane,
  input  logic [31:0]     wdata,
  input  logic [31:0]     rd_word,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wr_word,
  output logic [31:0]     rdata_ext
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    be        = '0;
    wr_word   = '0;
    rdata_ext = '0;
    half_sel  = lane[1] ? rd_word[31:16] : rd_word[15:0];
    byte_sel  = rd_word[8*lane +: 8];
    case (op)
      DM_W: begin
        be        = 4'hF;
        wr_word   = wdata;
        rdata_ext = rd_word;
      end
      DM_H, DM_HU: begin
        be        = lane[1] ? 4'hC : 4'h3;
        wr_word   = {2{wdata[15:0]}};
        rdata_ext = (op == DM_H) ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
      end
      DM_B, DM_BU: begin
        be        = 4'b0001 << lane;
        wr_word   = {4{wdata[7:0]}};
        rdata_ext = (op == DM_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_unit.sv
// rtl/dm_unit.sv - MIPS data memory: byte-lane stores on the edge, combinational loads
module dm_unit
  import mips_dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072
) (
  input logic       clk,
  input logic       reset,
  dm_unit_if.slave  bus
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [31:0]      word_d;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]      rd_word;
  logic [31:0]      lane_rdata;
  logic [31:0]      wr_word;
  logic [BE_W-1:0]  be;
  logic             misalign;
  logic             oor;
  logic             wr_en;

  assign word_idx = bus.addr[IDX_W+1:2];

  dm_lane u_lane (
    .op        (bus.op),
    .lane      (bus.addr[1:0]),
    .wdata     (bus.wdata),
    .rd_word   (rd_word),
    .be        (be),
    .wr_word   (wr_word),
    .rdata_ext (lane_rdata)
  );

  // Whole-address compare: high bits set must flag oor rather than wrap onto a low word.
  always_comb begin
    oor      = !(bus.addr < LIMIT);
    misalign = dm_misaligned(bus.op, bus.addr[1:0]);
    wr_en    = bus.we && !misalign && !oor;
    rd_word  = oor ? 32'b0 : mem_q[word_idx];
    word_d   = rd_word;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) word_d[8*b +: 8] = wr_word[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[word_idx] <= word_d;
    end
  end

  assign bus.rdata    = (misalign || oor) ? 32'b0 : lane_rdata;
  assign bus.misalign = misalign;
  assign bus.oor      = oor;

endmodule

// File: tb/tb_dm_unit.sv
// tb/tb_dm_unit.sv - directed self-checking bench for dm_unit
module tb_dm_unit;
  import mips_dm_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  dm_unit_if bus ();

  dm_unit #(.DEPTH_WORDS(3072)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic store(input logic [2:0] o, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.we = 1'b1; bus.op = o; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    #1 bus.we = 1'b0;
  endtask

  task automatic load(input logic [2:0] o, input logic [31:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus.we = 1'b0; bus.op = o; bus.addr = a;
    #1 check(tag, bus.rdata, exp);
  endtask

  task automatic flags(input logic [2:0] o, input logic [31:0] a, input logic [1:0] exp, input string tag);
    @(negedge clk);
    bus.we = 1'b0; bus.op = o; bus.addr = a;
    #1 check(tag, {30'b0, bus.misalign, bus.oor}, {30'b0, exp});
  endtask

  logic [31:0] r0, r1, r2;

  initial begin
    bus.we = 1'b0; bus.op = DM_W; bus.addr = '0; bus.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdata", bus.rdata, 32'h0);
    bus.addr = 32'h3000;
    #1 check("reset_oor_flag", {31'b0, bus.oor}, 32'h1);
    @(negedge clk) reset = 1'b1;

    r0 = $urandom; r1 = $urandom; r2 = $urandom;
    store(DM_W, 32'h0, r0);
    store(DM_W, 32'h4, r1);
    store(DM_W, 32'h2FFC, r2);
    load(DM_W, 32'h0, r0, "pre_reset_0");
    load(DM_W, 32'h2FFC, r2, "top_word_legal");
    flags(DM_W, 32'h2FFC, 2'b00, "top_word_flags");
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    load(DM_W, 32'h0, 32'h0, "clr_0");
    load(DM_W, 32'h4, 32'h0, "clr_4");
    load(DM_W, 32'h2FFC, 32'h0, "clr_2ffc");

    store(DM_W, 32'h10, 32'h12345678);
    load(DM_W, 32'h10, 32'h12345678, "lw_10");
    load(DM_B, 32'h13, 32'h00000012, "lb_13");
    load(DM_H, 32'h12, 32'h00001234, "lh_12");

    store(DM_W, 32'h20, 32'h80FF7F80);
    load(DM_B,  32'h20, 32'hFFFFFF80, "lb_sign");
    load(DM_BU, 32'h20, 32'h00000080, "lbu_zero");
    load(DM_H,  32'h22, 32'hFFFF80FF, "lh_sign");
    load(DM_HU, 32'h22, 32'h000080FF, "lhu_zero");
    load(DM_B,  32'h21, 32'h0000007F, "lb_pos");
    load(DM_HU, 32'h20, 32'h00007F80, "lhu_low");

    store(DM_W, 32'h30, 32'hAAAAAAAA);
    store(DM_B, 32'h31, 32'hFFFFFF55);
    store(DM_H, 32'h32, 32'hFFFF1234);
    load(DM_W, 32'h30, 32'h123455AA, "merge_30");

    store(DM_H,  32'h60, 32'h0000BEEF);
    store(DM_BU, 32'h62, 32'h0000007A);
    load(DM_W, 32'h60, 32'h007ABEEF, "hu_bu_store");

    store(DM_W, 32'h40, 32'hCAFEBABE);
    flags(DM_W, 32'h41, 2'b10, "sw_41_misalign");
    store(DM_W, 32'h41, 32'h11111111);
    load(DM_W, 32'h40, 32'hCAFEBABE, "sw_41_suppressed");
    store(DM_H, 32'h43, 32'h2222);
    load(DM_W, 32'h40, 32'hCAFEBABE, "sh_43_suppressed");
    flags(DM_H, 32'h42, 2'b00, "sh_42_aligned");
    flags(DM_W, 32'h3000, 2'b01, "sw_3000_oor");
    load(DM_W, 32'h3000, 32'h0, "oor_rdata");
    store(DM_W, 32'h3000, 32'h33333333);
    store(DM_W, 32'h80000040, 32'h44444444);
    load(DM_W, 32'h40, 32'hCAFEBABE, "no_wrap_store");
    flags(DM_B, 32'h80000000, 2'b01, "bit31_oor");
    flags(3'd5, 32'h40, 2'b10, "reserved_misalign");
    load(3'd5, 32'h40, 32'h0, "reserved_rdata");
    load(DM_H, 32'h41, 32'h0, "misalign_rdata");

    @(negedge clk);
    reset = 1'b0;
    bus.we = 1'b1; bus.op = DM_W; bus.addr = 32'h50; bus.wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 bus.we = 1'b0; reset = 1'b1;
    load(DM_W, 32'h50, 32'h0, "reset_beats_store");

    @(negedge clk);
    bus.we = 1'b1; bus.op = DM_W; bus.addr = 32'h54; bus.wdata = 32'h1;
    #1 check("rbw_old", bus.rdata, 32'h0);
    @(posedge clk);
    #1 bus.we = 1'b0;
    check("rbw_new", bus.rdata, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dm_unit.md
# dm_unit

Data memory for the single-cycle MIPS datapath, directly downstream of the ALU. The ALU result is the byte address and the rt register value is the store data. The block performs word, halfword and byte stores on the clock edge. Loads are combinational, with sign or zero extension, and the result feeds the register-file write-back mux. Misaligned and out-of-range accesses are detected and suppressed, never silently corrupting memory.

## Interface
Parameters:
- DEPTH_WORDS, 3072: number of 32-bit words; valid byte addresses are 0 to DEPTH_WORDS*4-1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low; memory cleared on a rising edge while reset==0.
- we  input  1  store enable for this instruction.
- op  input  3  access width/extension: 0=W, 1=H, 2=B, 3=HU, 4=BU; 5–7 reserved.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data; low 8/16 bits used for B/H.
- rdata  output  32  load result, extended per op.
- misalign  output  1  access address not aligned to op width.
- oor  output  1  address ≥ DEPTH_WORDS*4.

## Operation
- Word index = addr[31:2]; byte lane = addr[1:0].
- Alignment rules:
  - W requires addr[1:0]==0.
  - H/HU require addr[0]==0.
  - B/BU are always aligned.
  - Reserved op counts as misaligned.
- Store (we=1, reset=1, misalign=0, oor=0):
  - W writes all 4 bytes.
  - H writes bytes {1,0} for addr[1]==0, bytes {3,2} for addr[1]==1, from wdata[15:0].
  - B writes byte addr[1:0] from wdata[7:0].
  - Unselected bytes keep their value.
  - HU/BU with we=1 behave as H/B.
- Suppressed store (misalign or oor): memory unchanged, flags asserted.
- Load: selects the lane per addr[1:0] exactly as for stores.
  - H/B sign-extend; HU/BU zero-extend.
  - rdata=0 when misalign or oor.
- Flags are combinational from addr/op and are valid regardless of we.
- Reset: every word is cleared to 0 on the edge. Reset beats a same-edge store, so the store is lost.
- Outputs during/after reset: rdata=0 (memory is zero), misalign/oor depend only on inputs.

## Timing
- Store latency: 1 edge.
- Load latency: 0 cycles (combinational from addr/op and memory contents).
- A load in the same cycle as a store to the same word returns the pre-store value. The stored value is visible from the cycle after the edge.
- No handshake; one access per cycle; we is sampled only at the edge.
- Boundary addresses:
  - Address DEPTH_WORDS*4-4 with op W is legal.
  - Address DEPTH_WORDS*4 is oor.
  - Addresses with addr[31]=1 are oor, with no wrap-around.
- Reset asserted mid-program takes effect at the next edge, independent of we/op.

## Structure
- Shared package mips_dm_pkg holds:
  - op codes DM_W, DM_H, DM_B, DM_HU, DM_BU;
  - the byte-enable width constant (4).
- One sub-module, dm_lane (combinational), produces from op/addr/wdata:
  - the 4-bit byte enable;
  - the lane-positioned write word;
  - from the read word, the extended rdata.
- The top holds the storage array, the reset clear, address range check and flag logic.

## Test plan
- Reset clear: hold reset=0 one edge after random stores, then load W at 0x0, 0x4, 0x2FFC → rdata=0x00000000 each.
- Word store/load: store W 0x12345678 at 0x10, then load at 0x10:
  - op W → 0x12345678;
  - op B at 0x13 → 0x00000012;
  - op H at 0x12 → 0x00001234.
- Sign vs zero extension: store W 0x80FF7F80 at 0x20, then load:
  - B at 0x20 → 0xFFFFFF80;
  - BU at 0x20 → 0x00000080;
  - H at 0x22 → 0xFFFF80FF;
  - HU at 0x22 → 0x000080FF.
- Partial store merge: store W 0xAAAAAAAA at 0x30, then sb 0x55 at 0x31, then sh 0x1234 at 0x32 → load W at 0x30 = 0x123455AA.
- Misalign/oor suppression: with 0x40 holding 0xCAFEBABE:
  - sw at 0x41 → misalign=1, word at 0x40 unchanged;
  - sw at 0x3000 → oor=1, rdata=0, no memory change.
- Same-edge reset and read-before-write:
  - store at 0x50 with reset=0 → word at 0x50 stays 0;
  - store 0x1 at 0x54 while loading 0x54 → rdata shows the old value in that cycle and 0x1 in the next.
